// File: rtl/pipeline_ctrl_if.sv
// Request/enable bundle between the hazard, branch and jump logic and the
// pipeline stall/flush sequencer.
interface pipeline_ctrl_if;
    logic       hazard_stall;
    logic       branch_taken_ex;
    logic       jump_id;
    logic       mem_wait;
    logic       mdu_start_id;
    logic [1:0] mdu_op_id;
    logic       hilo_read_id;

    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_write;
    logic       id_ex_flush;
    logic       ex_mem_write;
    logic       mdu_latch;
    logic       mdu_busy;
    logic       mdu_done;

    modport master (
        output hazard_stall, branch_taken_ex, jump_id, mem_wait,
               mdu_start_id, mdu_op_id, hilo_read_id,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, mdu_latch, mdu_busy, mdu_done
    );

    modport slave (
        input  hazard_stall, branch_taken_ex, jump_id, mem_wait,
               mdu_start_id, mdu_op_id, hilo_read_id,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, mdu_latch, mdu_busy, mdu_done
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Prioritized stall/flush sequencer for the 5-stage pipeline, plus the
// issue/occupancy tracker for the shared multi-cycle multiply/divide unit.
module pipeline_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_ctrl_if.slave       bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    logic busy;
    logic done;
    logic id_stall;
    logic latch;

    assign busy     = (state == BUSY);
    assign done     = busy && (cnt == CNT_W'(1));
    // A queued MDU op may issue in the done cycle, giving zero-gap back-to-back.
    assign id_stall = bus.hazard_stall
                    | (bus.hilo_read_id & busy)
                    | (bus.mdu_start_id & busy & ~done);

    assign bus.mdu_busy  = busy;
    assign bus.mdu_done  = done;
    assign bus.mdu_latch = latch;

    // NOTE: every signal written below gets a default first so no latch is inferred.
    always_comb begin
        bus.pc_write     = 1'b1;
        bus.if_id_write  = 1'b1;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_write  = 1'b1;
        bus.id_ex_flush  = 1'b0;
        bus.ex_mem_write = 1'b1;
        latch            = 1'b0;

        if (reset) begin
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.id_ex_write  = 1'b0;
            bus.ex_mem_write = 1'b0;
            bus.if_id_flush  = 1'b1;
            bus.id_ex_flush  = 1'b1;
        end else if (bus.mem_wait) begin
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.id_ex_write  = 1'b0;
            bus.ex_mem_write = 1'b0;
        end else if (bus.branch_taken_ex) begin
            // ID holds a wrong-path instruction: squash it, never issue it to the MDU.
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (id_stall) begin
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
            bus.id_ex_flush = 1'b1;
        end else if (bus.jump_id) begin
            bus.if_id_flush = 1'b1;
            latch           = bus.mdu_start_id;
        end else begin
            latch           = bus.mdu_start_id;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (latch) begin
            state_nxt = BUSY;
            cnt_nxt   = bus.mdu_op_id[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (busy) begin
            cnt_nxt = cnt - CNT_W'(1);
            if (done)
                state_nxt = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl: priority cases, MDU
// occupancy timing, back-to-back issue, freeze and mid-operation reset.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(
        .MULT_CYCLES (4),
        .DIV_CYCLES  (32),
        .CNT_W       (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Expected vector order:
    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
    //  ex_mem_write, mdu_latch, mdu_busy, mdu_done}
    localparam logic [8:0] RST_V  = 9'b0_0_1_0_1_0_0_0_0;
    localparam logic [8:0] RUN    = 9'b1_1_0_1_0_1_0_0_0;
    localparam logic [8:0] RUN_B  = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] RUN_D  = 9'b1_1_0_1_0_1_0_1_1;
    localparam logic [8:0] STL    = 9'b0_0_0_1_1_1_0_0_0;
    localparam logic [8:0] STL_B  = 9'b0_0_0_1_1_1_0_1_0;
    localparam logic [8:0] STL_D  = 9'b0_0_0_1_1_1_0_1_1;
    localparam logic [8:0] JMP    = 9'b1_1_1_1_0_1_0_0_0;
    localparam logic [8:0] BRF    = 9'b1_1_1_1_1_1_0_0_0;
    localparam logic [8:0] LATCH  = 9'b1_1_0_1_0_1_1_0_0;
    localparam logic [8:0] LAT_D  = 9'b1_1_0_1_0_1_1_1_1;
    localparam logic [8:0] FRZ_B  = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] RST_B  = 9'b0_0_1_0_1_0_0_1_0;

    function automatic logic [8:0] observed();
        return {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_write,
                bus.id_ex_flush, bus.ex_mem_write, bus.mdu_latch, bus.mdu_busy,
                bus.mdu_done};
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Inputs are set just after a rising edge; outputs sampled mid-cycle,
    // then time advances to just after the next rising edge.
    task automatic step(input string tag, input logic [8:0] exp);
        #3;
        check(tag, observed(), exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.hazard_stall    = 1'b0;
        bus.branch_taken_ex = 1'b0;
        bus.jump_id         = 1'b0;
        bus.mem_wait        = 1'b0;
        bus.mdu_start_id    = 1'b0;
        bus.mdu_op_id       = 2'b00;
        bus.hilo_read_id    = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        step("reset_hold", RST_V);
        reset = 1'b0;
        step("after_reset", RUN);
        step("idle", RUN);

        // Hazard stall masks a jump; the jump is retried once the stall clears.
        bus.hazard_stall = 1'b1;
        bus.jump_id      = 1'b1;
        step("stall_over_jump", STL);
        bus.hazard_stall = 1'b0;
        step("jump_retry", JMP);
        bus.jump_id = 1'b0;

        // Branch flush overrides stall and a wrong-path MDU start.
        bus.branch_taken_ex = 1'b1;
        bus.hazard_stall    = 1'b1;
        bus.mdu_start_id    = 1'b1;
        step("branch_wins", BRF);
        idle_inputs();
        step("branch_no_mdu", RUN);

        // mult issued in cycle 0, mfhi waits in ID from cycle 1.
        bus.mdu_start_id = 1'b1;
        bus.mdu_op_id    = 2'b00;
        step("mult_latch", LATCH);
        bus.mdu_start_id = 1'b0;
        bus.hilo_read_id = 1'b1;
        for (int c = 1; c <= 3; c++) step($sformatf("mfhi_stall_c%0d", c), STL_B);
        step("mfhi_stall_done_c4", STL_D);
        step("mfhi_release_c5", RUN);
        idle_inputs();

        // div followed immediately by another div.
        bus.mdu_start_id = 1'b1;
        bus.mdu_op_id    = 2'b10;
        step("div1_latch", LATCH);
        for (int c = 1; c <= 31; c++) step($sformatf("div2_stall_c%0d", c), STL_B);
        step("div2_latch_c32", LAT_D);
        bus.mdu_start_id = 1'b0;
        for (int c = 33; c <= 63; c++) step($sformatf("div2_busy_c%0d", c), RUN_B);
        step("div2_done_c64", RUN_D);
        step("div2_idle_c65", RUN);

        // mult with memory freeze in cycles 2-3; counter keeps running.
        bus.mdu_start_id = 1'b1;
        bus.mdu_op_id    = 2'b01;
        step("mw_mult_latch", LATCH);
        bus.mdu_start_id = 1'b0;
        step("mw_busy_c1", RUN_B);
        bus.mem_wait     = 1'b1;
        bus.mdu_start_id = 1'b1;
        step("mw_freeze_c2", FRZ_B);
        step("mw_freeze_c3", FRZ_B);
        bus.mem_wait     = 1'b0;
        bus.mdu_start_id = 1'b0;
        step("mw_done_c4", RUN_D);
        step("mw_idle_c5", RUN);

        // Freeze during the done cycle: done still fires, no issue.
        bus.mdu_start_id = 1'b1;
        bus.mdu_op_id    = 2'b00;
        step("fd_latch", LATCH);
        bus.mem_wait = 1'b1;
        for (int c = 1; c <= 3; c++) step($sformatf("fd_freeze_c%0d", c), FRZ_B);
        step("fd_freeze_done_c4", 9'b0_0_0_0_0_0_0_1_1);
        step("fd_freeze_idle_c5", 9'b0_0_0_0_0_0_0_0_0);
        idle_inputs();

        // Reset in cycle 2 of a div abandons it with no done pulse.
        bus.mdu_start_id = 1'b1;
        bus.mdu_op_id    = 2'b11;
        step("rd_div_latch", LATCH);
        bus.mdu_start_id = 1'b0;
        step("rd_busy_c1", RUN_B);
        reset = 1'b1;
        step("rd_reset_c2", RST_B);
        reset = 1'b0;
        for (int c = 3; c <= 40; c++) step($sformatf("rd_idle_c%0d", c), RUN);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
